fb_muldiv: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage, fed by the M-extension bits of the ALU control word.

---
 rtl/fb_muldiv_pkg.sv | 31 +++
 rtl/fb_cond_neg.sv | 13 +
 rtl/fb_muldiv.sv | 140 ++++++++++++++
 tb/tb_fb_muldiv.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_muldiv_pkg.sv
// Shared widths, M-extension op bit positions, FSM states and the latched
// per-op control word for the iterative multiply/divide unit.
package fb_muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  // Bit positions inside md_op = {mul,mulh,mulhsu,mulhu,div,divu,rem,remu}
  localparam int unsigned MD_MUL    = 7;
  localparam int unsigned MD_MULH   = 6;
  localparam int unsigned MD_MULHSU = 5;
  localparam int unsigned MD_MULHU  = 4;
  localparam int unsigned MD_DIV    = 3;
  localparam int unsigned MD_DIVU   = 2;
  localparam int unsigned MD_REM    = 1;
  localparam int unsigned MD_REMU   = 0;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic is_mul;  // multiply family, else divide family
    logic is_rem;  // remainder result wanted
    logic mul_lo;  // return low half of the product
    logic neg;     // negate the final result
  } md_ctl_t;

endpackage

// File: rtl/fb_cond_neg.sv
// Conditional two's-complement negate: used for operand magnitudes and
// for the final sign fix-up of products, quotients and remainders.
module fb_cond_neg #(
  parameter int unsigned W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_in,
  output logic [W-1:0] o_out
);

  assign o_out = i_neg ? (~i_in + W'(1)) : i_in;

endmodule

// File: rtl/fb_muldiv.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply or restoring
// divide over a shared 64-bit accumulator; divide special cases finish early.
module fb_muldiv
  import fb_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            md_start,
  input  logic [7:0]      md_op,
  input  logic [XLEN-1:0] md_src1,
  input  logic [XLEN-1:0] md_src2,
  input  logic            md_flush,
  output logic            md_busy,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result
);

  md_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [2*XLEN-1:0] r_acc, w_acc_nxt, w_step, w_prod_fix;
  logic [XLEN-1:0]   r_opb, w_opb_nxt;
  logic [XLEN-1:0]   r_result, w_result_nxt;
  md_ctl_t           r_ctl, w_ctl_nxt;

  logic [XLEN-1:0]   w_abs1, w_abs2, w_div_sel, w_div_fix, w_final, w_rem_sub;
  logic [XLEN:0]     w_mul_sum, w_rem_shift;
  logic              w_rem_ge;
  logic              w_onehot, w_accept, w_in_mul, w_in_rem;
  logic              w_sign1, w_sign2, w_neg_res, w_div_zero, w_ovf;

  // Accept-time decode of the incoming request
  assign w_onehot   = (md_op != 8'd0) && ((md_op & (md_op - 8'd1)) == 8'd0);
  assign w_accept   = (r_state == MD_IDLE) && md_start && w_onehot && !md_flush;
  assign w_in_mul   = |md_op[MD_MUL:MD_MULHU];
  assign w_in_rem   = md_op[MD_REM] | md_op[MD_REMU];
  assign w_sign1    = (md_op[MD_MULH] | md_op[MD_MULHSU] | md_op[MD_DIV] | md_op[MD_REM])
                      & md_src1[XLEN-1];
  assign w_sign2    = (md_op[MD_MULH] | md_op[MD_DIV] | md_op[MD_REM]) & md_src2[XLEN-1];
  assign w_neg_res  = w_in_rem ? w_sign1 : (w_sign1 ^ w_sign2);
  assign w_div_zero = !w_in_mul && (md_src2 == '0);
  assign w_ovf      = (md_op[MD_DIV] | md_op[MD_REM])
                      && (md_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (md_src2 == '1);

  fb_cond_neg #(.W(XLEN)) u_abs1 (.i_neg(w_sign1), .i_in(md_src1), .o_out(w_abs1));
  fb_cond_neg #(.W(XLEN)) u_abs2 (.i_neg(w_sign2), .i_in(md_src2), .o_out(w_abs2));

  // One iteration: multiply adds on multiplier LSB; divide restores on borrow
  assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_rem_shift = r_acc[2*XLEN-1:XLEN-1];
  assign w_rem_ge    = w_rem_shift >= {1'b0, r_opb};
  assign w_rem_sub   = w_rem_shift[XLEN-1:0] - r_opb;

  always_comb begin
    if (r_ctl.is_mul) begin
      w_step = {w_mul_sum, r_acc[XLEN-1:1]};
    end else if (w_rem_ge) begin
      w_step = {w_rem_sub, r_acc[XLEN-2:0], 1'b1};
    end else begin
      w_step = {w_rem_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up applied to the result of the final step
  fb_cond_neg #(.W(2*XLEN)) u_fix_prod (.i_neg(r_ctl.neg), .i_in(w_step), .o_out(w_prod_fix));

  assign w_div_sel = r_ctl.is_rem ? w_step[2*XLEN-1:XLEN] : w_step[XLEN-1:0];

  fb_cond_neg #(.W(XLEN)) u_fix_div (.i_neg(r_ctl.neg), .i_in(w_div_sel), .o_out(w_div_fix));

  assign w_final = !r_ctl.is_mul ? w_div_fix
                 : (r_ctl.mul_lo ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN]);

  // Next-state and datapath update
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_opb_nxt    = r_opb;
    w_ctl_nxt    = r_ctl;
    w_result_nxt = r_result;
    unique case (r_state)
      MD_IDLE: begin
        if (w_accept) begin
          w_ctl_nxt = '{is_mul: w_in_mul, is_rem: w_in_rem, mul_lo: md_op[MD_MUL], neg: w_neg_res};
          w_cnt_nxt = CNT_W'(XLEN - 1);
          if (w_div_zero) begin
            w_state_nxt  = MD_DONE;
            w_result_nxt = w_in_rem ? md_src1 : '1;
          end else if (w_ovf) begin
            w_state_nxt  = MD_DONE;
            w_result_nxt = w_in_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
          end else begin
            w_state_nxt = MD_CALC;
            w_acc_nxt   = {{XLEN{1'b0}}, (w_in_mul ? w_abs2 : w_abs1)};
            w_opb_nxt   = w_in_mul ? w_abs1 : w_abs2;
          end
        end
      end
      MD_CALC: begin
        w_acc_nxt = w_step;
        if (r_cnt == '0) begin
          w_state_nxt  = MD_DONE;
          w_result_nxt = w_final;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      MD_DONE: w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
    // A flush kills whatever is in flight and leaves the last result alone
    if (md_flush) begin
      w_state_nxt  = MD_IDLE;
      w_result_nxt = r_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= MD_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_ctl    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_opb    <= w_opb_nxt;
      r_ctl    <= w_ctl_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign md_busy   = (r_state != MD_IDLE);
  assign md_valid  = (r_state == MD_DONE) && !md_flush;
  assign md_result = r_result;

endmodule

// File: tb/tb_fb_muldiv.sv
// Self-checking bench for fb_muldiv: vector table plus scoreboard queue,
// and hand-written flush / reset / illegal-op sequences.
module tb_fb_muldiv;

  localparam logic [7:0] OP_MUL    = 8'h80;
  localparam logic [7:0] OP_MULH   = 8'h40;
  localparam logic [7:0] OP_MULHSU = 8'h20;
  localparam logic [7:0] OP_MULHU  = 8'h10;
  localparam logic [7:0] OP_DIV    = 8'h08;
  localparam logic [7:0] OP_DIVU   = 8'h04;
  localparam logic [7:0] OP_REM    = 8'h02;
  localparam logic [7:0] OP_REMU   = 8'h01;

  typedef struct {
    string       nm;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] res;
    int          lat;
  } sb_t;

  logic        clk, rst, md_start, md_flush;
  logic [7:0]  md_op;
  logic [31:0] md_src1, md_src2;
  logic        md_busy, md_valid;
  logic [31:0] md_result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = 32'd0;
  vec_t        tv[$];
  sb_t         scb[$];

  fb_muldiv dut (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_start),
    .md_op    (md_op),
    .md_src1  (md_src1),
    .md_src2  (md_src2),
    .md_flush (md_flush),
    .md_busy  (md_busy),
    .md_valid (md_valid),
    .md_result(md_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model built from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [7:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned za, zb;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    za = {32'd0, a};
    zb = {32'd0, b};
    p  = 64'd0;
    case (op)
      OP_MUL:    begin p = za * zb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(zb); return p[63:32]; end
      OP_MULHU:  begin p = za * zb; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU:   return (b == 32'd0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic int lat_of(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    if ((op & 8'h0F) != 8'd0 && b == 32'd0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op, hold md_start until md_valid, scramble inputs after accept
  task automatic run_op(input vec_t v);
    sb_t e;
    bit  got;
    @(negedge clk);
    md_start = 1'b1;
    md_op    = v.op;
    md_src1  = v.a;
    md_src2  = v.b;
    e.nm  = v.nm;
    e.res = v.exp;
    e.lat = v.lat;
    scb.push_back(e);
    @(posedge clk);
    got = 1'b0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (n == 1) chk({v.nm, " busy@t+1"}, 32'(md_busy), 32'd1);
      md_src1 = $urandom;
      md_src2 = $urandom;
      md_op   = (v.op == OP_MUL) ? OP_DIVU : OP_MUL;
      if (md_valid) begin
        got = 1'b1;
        e = scb.pop_front();
        chk({e.nm, " result"}, md_result, e.res);
        chk({e.nm, " latency"}, 32'(n), 32'(e.lat));
        chk({e.nm, " busy@valid"}, 32'(md_busy), 32'd1);
        last_res = e.res;
        md_start = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no md_valid within 40 cycles, expected at %0d", v.nm, v.lat);
      md_start = 1'b0;
      void'(scb.pop_front());
    end
    @(negedge clk);
    chk({v.nm, " valid one-shot"}, 32'(md_valid), 32'd0);
    chk({v.nm, " idle after"}, 32'(md_busy), 32'd0);
  endtask

  task automatic add_vec(input string nm, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    vec_t v;
    v.nm = nm; v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    tv.push_back(v);
  endtask

  initial begin
    int vcnt;
    rst = 1'b1; md_start = 1'b0; md_flush = 1'b0; md_op = 8'd0;
    md_src1 = 32'd0; md_src2 = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(md_busy), 32'd0);
    chk("reset valid", 32'(md_valid), 32'd0);
    chk("reset result", md_result, 32'd0);
    rst = 1'b0;

    add_vec("mul 7*-3",        OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    add_vec("mulh min*min",    OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
    add_vec("mulhu max*max",   OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    add_vec("mulhsu -1*max",   OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    add_vec("div -7/2",        OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    add_vec("rem -7%2",        OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    add_vec("divu 100/7",      OP_DIVU,   32'd100,        32'd7,         32'd14,        33);
    add_vec("remu 100%7",      OP_REMU,   32'd100,        32'd7,         32'd2,         33);
    add_vec("div 5/0",         OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    add_vec("rem 5%0",         OP_REM,    32'd5,          32'd0,         32'd5,         1);
    add_vec("div ovf",         OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    add_vec("rem ovf",         OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    add_vec("divu max/1",      OP_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33);
    add_vec("rem 7%-3",        OP_REM,    32'd7,          32'hFFFF_FFFD, 32'd1,         33);
    for (int i = 0; i < 12; i++) begin
      logic [7:0]  op;
      logic [31:0] a, b;
      op = 8'd1 << $urandom_range(0, 7);
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = -b;
      add_vec($sformatf("rand%0d op%02h", i, op), op, a, b, model(op, a, b), lat_of(op, a, b));
    end
    for (int i = 0; i < tv.size(); i++) run_op(tv[i]);

    // Flush mid-divide: op killed, no pulse, result retained
    @(negedge clk);
    md_start = 1'b1; md_op = OP_DIV; md_src1 = 32'hFFFF_FF9C; md_src2 = 32'd7;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) @(negedge clk);
    md_flush = 1'b1; md_start = 1'b0;
    @(negedge clk);
    md_flush = 1'b0;
    chk("flush calc idle", 32'(md_busy), 32'd0);
    vcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (md_valid) vcnt++;
    end
    chk("flush calc no valid", 32'(vcnt), 32'd0);
    chk("flush calc result kept", md_result, last_res);
    run_op('{"div after flush", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33});

    // Flush in DONE cycle suppresses the pulse combinationally
    @(negedge clk);
    md_start = 1'b1; md_op = OP_DIVU; md_src1 = 32'd9; md_src2 = 32'd0;
    @(posedge clk);
    @(negedge clk);
    md_flush = 1'b1;
    #1;
    chk("flush done valid", 32'(md_valid), 32'd0);
    chk("flush done busy", 32'(md_busy), 32'd1);
    md_start = 1'b0;
    @(negedge clk);
    md_flush = 1'b0;
    chk("flush done idle", 32'(md_busy), 32'd0);

    // Flush and start together in IDLE: no accept
    md_start = 1'b1; md_flush = 1'b1; md_op = OP_DIVU; md_src1 = 32'd50; md_src2 = 32'd5;
    @(negedge clk);
    chk("flush+start no accept", 32'(md_busy), 32'd0);
    md_start = 1'b0; md_flush = 1'b0;

    // Illegal op encodings never accepted
    md_start = 1'b1; md_op = 8'b0000_0011;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("multi-hot op busy", 32'(md_busy | md_valid), 32'd0);
    end
    md_op = 8'd0;
    @(negedge clk);
    chk("zero op busy", 32'(md_busy | md_valid), 32'd0);
    md_start = 1'b0;

    // Async reset mid-CALC clears outputs without a clock edge
    run_op('{"mulhu pre-reset", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    @(negedge clk);
    md_start = 1'b1; md_op = OP_MUL; md_src1 = 32'd123; md_src2 = 32'd456;
    @(posedge clk);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst busy", 32'(md_busy), 32'd0);
    chk("async rst valid", 32'(md_valid), 32'd0);
    chk("async rst result", md_result, 32'd0);
    md_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op('{"mul after reset", OP_MUL, 32'd123, 32'd456, 32'd56088, 33});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
